// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map and bit indices shared by the timer bank
package timer_pkg;

  // Register offsets inside one channel window
  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_SNAPSHOT = 3'd3,
    REG_IRQ_PEND = 3'd4,
    REG_PRESCALE = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_off_e;

  // CONTROL bits: ITO/CONT are stored, START/STOP are write-only strobes
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // STATUS bits
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting interval timer with snapshot and timeout irq
module timer_channel
  import timer_pkg::*;
#(
  parameter int          COUNTER_WIDTH = 32,
  parameter logic [31:0] INIT_PERIOD   = 32'h22E97
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     wr_status,
  input  logic                     wr_control,
  input  logic                     wr_period,
  input  logic                     wr_snapshot,
  input  logic [COUNTER_WIDTH-1:0] wdata,
  output logic                     to,
  output logic                     run,
  output logic                     ito,
  output logic                     cont,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] snapshot,
  output logic                     irq
);

  localparam logic [COUNTER_WIDTH-1:0] INIT_VAL = INIT_PERIOD[COUNTER_WIDTH-1:0];

  logic [COUNTER_WIDTH-1:0] counter;
  logic                     force_reload;
  logic                     zero_d;
  logic                     is_zero;
  logic                     timeout;
  logic                     start;
  logic                     stop;

  assign is_zero = (counter == '0);
  // Edge detect so a period of 0 in continuous mode fires only once
  assign timeout = is_zero && !zero_d;
  assign start   = wr_control && wdata[CTL_START];
  assign stop    = wr_control && wdata[CTL_STOP];
  assign irq     = to && ito;

  // Stored control bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ito  <= 1'b0;
      cont <= 1'b0;
    end else if (wr_control) begin
      ito  <= wdata[CTL_ITO];
      cont <= wdata[CTL_CONT];
    end
  end

  // Period register; a write schedules a counter reload on the following clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period       <= INIT_VAL;
      force_reload <= 1'b0;
    end else begin
      force_reload <= wr_period;
      if (wr_period) period <= wdata;
    end
  end

  // Live counter and its zero history; reload acts on clk, counting only on tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= INIT_VAL;
      zero_d  <= (INIT_VAL == '0);
    end else begin
      zero_d <= is_zero;
      if (force_reload)      counter <= period;
      else if (run && tick)  counter <= is_zero ? period : counter - 1'b1;
    end
  end

  // RUN: reload beats START, START beats STOP, one-shot timeout stops the channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
    end else if (force_reload) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
    end else if (stop || (timeout && !cont)) begin
      run <= 1'b0;
    end
  end

  // TO: a status write clears it even when a timeout lands on the same clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          to <= 1'b0;
    else if (wr_status) to <= 1'b0;
    else if (timeout)   to <= 1'b1;
  end

  // Snapshot capture of the live counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            snapshot <= '0;
    else if (wr_snapshot) snapshot <= counter;
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// rtl/avalon_multi_timer.sv - NUM_CH interval timers on a 32-bit Avalon-MM slave; optional TIMER_PRESCALER_EN
module avalon_multi_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH        = 2,
  parameter int          COUNTER_WIDTH = 32,
  parameter logic [31:0] INIT_PERIOD   = 32'h22E97
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NUM_CH)+2:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          irq_vec
);

  localparam int AW = $clog2(NUM_CH) + 3;

  logic [AW-1:0] ch_sel;
  reg_off_e      reg_sel;
  logic          ch_ok;
  logic          wr_en;
  logic          tick;
  logic [31:0]   rd_mux;

  logic [NUM_CH-1:0]        to_vec;
  logic [NUM_CH-1:0]        run_vec;
  logic [NUM_CH-1:0]        ito_vec;
  logic [NUM_CH-1:0]        cont_vec;
  logic [COUNTER_WIDTH-1:0] period_arr   [NUM_CH];
  logic [COUNTER_WIDTH-1:0] snapshot_arr [NUM_CH];

  assign ch_sel  = address >> 3;
  assign reg_sel = reg_off_e'(address[2:0]);
  assign ch_ok   = (ch_sel < AW'(NUM_CH));
  assign wr_en   = chipselect && !write_n && ch_ok;

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale;
  logic [15:0] pre_cnt;
  logic        wr_prescale;

  assign wr_prescale = wr_en && (reg_sel == REG_PRESCALE);
  assign tick        = (pre_cnt == '0);

  // Shared prescaler: tick once every prescale+1 clocks, restarted by a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else if (wr_prescale) begin
      prescale <= writedata[15:0];
      pre_cnt  <= writedata[15:0];
    end else if (pre_cnt == '0) begin
      pre_cnt  <= prescale;
    end else begin
      pre_cnt  <= pre_cnt - 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr_en && (ch_sel == AW'(i));

    timer_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .INIT_PERIOD   (INIT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .wr_status   (sel && (reg_sel == REG_STATUS)),
      .wr_control  (sel && (reg_sel == REG_CONTROL)),
      .wr_period   (sel && (reg_sel == REG_PERIOD)),
      .wr_snapshot (sel && (reg_sel == REG_SNAPSHOT)),
      .wdata       (writedata[COUNTER_WIDTH-1:0]),
      .to          (to_vec[i]),
      .run         (run_vec[i]),
      .ito         (ito_vec[i]),
      .cont        (cont_vec[i]),
      .period      (period_arr[i]),
      .snapshot    (snapshot_arr[i]),
      .irq         (irq_vec[i])
    );
  end

  assign irq = |irq_vec;

  // Read mux from the decoded address; unmapped channels and offsets read 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_STATUS: begin
            rd_mux[ST_TO]  = to_vec[i];
            rd_mux[ST_RUN] = run_vec[i];
          end
          REG_CONTROL: begin
            rd_mux[CTL_ITO]  = ito_vec[i];
            rd_mux[CTL_CONT] = cont_vec[i];
          end
          REG_PERIOD:   rd_mux = 32'(period_arr[i]);
          REG_SNAPSHOT: rd_mux = 32'(snapshot_arr[i]);
          REG_IRQ_PEND: rd_mux = 32'(to_vec);
`ifdef TIMER_PRESCALER_EN
          REG_PRESCALE: rd_mux = 32'(prescale);
`endif
          default:      rd_mux = '0;
        endcase
      end
    end
  end

  // Registered read data, one cycle after the address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// tb/tb_avalon_multi_timer.sv - directed self-checking bench for avalon_multi_timer
module tb_avalon_multi_timer;

  localparam int NUM_CH = 3;
  localparam int AW     = $clog2(NUM_CH) + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  logic [NUM_CH-1:0] irq_vec;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] rd;

  avalon_multi_timer #(
    .NUM_CH        (NUM_CH),
    .COUNTER_WIDTH (32),
    .INIT_PERIOD   (32'h22E97)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int ch, input int r);
    return AW'(ch * 8 + r);
  endfunction

  // All bus tasks start and end on a falling edge and span exactly one rising edge
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    address    = addr_of(ch, r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [31:0] d);
    address    = addr_of(ch, r);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    idle(2);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    // Reset values in every channel window
    for (int c = 0; c < NUM_CH; c++) begin
      bus_read(c, 2, rd); check($sformatf("rst_period%0d", c), rd, 32'h22E97);
      bus_read(c, 0, rd); check($sformatf("rst_status%0d", c), rd, 32'h0);
      bus_read(c, 1, rd); check($sformatf("rst_control%0d", c), rd, 32'h0);
    end
    check("rst_irq_vec", 32'(irq_vec), 32'h0);

    // Ch0 one-shot: START in the reload cycle is lost, then a real START
    bus_write(0, 2, 32'd5);
    bus_write(0, 1, 32'h5);
    bus_read(0, 0, rd);  check("start_in_reload", rd, 32'h0);
    bus_write(0, 1, 32'h5);
    idle(5);             check("oneshot_pre_irq", {31'b0, irq}, 32'h0);
    idle(1);             check("oneshot_irq", {31'b0, irq}, 32'h1);
    check("oneshot_irq_vec", 32'(irq_vec), 32'h1);
    bus_read(0, 0, rd);  check("oneshot_status", rd, 32'h1);
    bus_write(0, 0, 32'h0);
    check("status_clear_irq", {31'b0, irq}, 32'h0);

    // Ch1 continuous, period 3: events every 4 clocks
    bus_write(1, 2, 32'd3);
    idle(1);
    bus_write(1, 1, 32'h7);
    idle(3);             check("cont_pre_event", 32'(irq_vec), 32'h0);
    idle(1);             check("cont_event1", 32'(irq_vec), 32'h2);
    bus_read(0, 4, rd);  check("irq_pend_ch0_win", rd, 32'h2);
    bus_write(1, 0, 32'h0);
    check("cont_clear", 32'(irq_vec), 32'h0);
    idle(2);             check("cont_event2", 32'(irq_vec), 32'h2);
    idle(3);
    bus_write(1, 0, 32'h0);
    check("clear_beats_event", 32'(irq_vec), 32'h0);
    idle(4);             check("cont_event4", 32'(irq_vec), 32'h2);
    bus_write(1, 1, 32'h8);
    bus_write(1, 0, 32'h0);
    bus_read(1, 0, rd);  check("ch1_stopped", rd, 32'h0);

    // Ch0 snapshot at count 60, then a mid-run period write
    bus_write(0, 2, 32'd100);
    idle(1);
    bus_write(0, 1, 32'h4);
    idle(40);
    bus_write(0, 3, 32'h0);
    bus_read(0, 3, rd);  check("snapshot_60", rd, 32'd60);
    bus_write(0, 2, 32'd50);
    idle(1);
    bus_read(0, 0, rd);  check("period_wr_stops", rd, 32'h0);
    bus_write(0, 3, 32'h0);
    bus_read(0, 3, rd);  check("period_wr_reload", rd, 32'd50);

    // START and STOP together: START wins
    bus_write(0, 1, 32'hC);
    bus_read(0, 0, rd);  check("start_stop", rd, 32'h2);
    bus_write(0, 1, 32'h8);
    bus_read(0, 0, rd);  check("stop", rd, 32'h0);

    // Channel index NUM_CH and reserved offsets
    bus_write(NUM_CH, 2, 32'h1234);
    bus_read(NUM_CH, 2, rd); check("oob_read", rd, 32'h0);
    bus_read(0, 2, rd);      check("oob_no_effect", rd, 32'd50);
    bus_read(0, 6, rd);      check("rsvd6", rd, 32'h0);
`ifdef TIMER_PRESCALER_EN
    begin
      int n;
      bus_write(2, 5, 32'd3);
      bus_read(0, 5, rd);    check("prescale_rd", rd, 32'd3);
      bus_write(2, 2, 32'd2);
      idle(1);
      bus_write(2, 1, 32'h5);
      n = 1;
      while (irq_vec[2] !== 1'b1 && n < 20) begin
        idle(1);
        n++;
      end
      check("prescale_timeout_lo", 32'(n > 4), 32'h1);
      check("prescale_timeout_hi", 32'(n <= 12), 32'h1);
    end
`else
    bus_read(0, 5, rd);      check("prescale_absent", rd, 32'h0);
`endif

    // Asynchronous reset mid-count
    bus_write(0, 1, 32'h6);
    bus_read(0, 2, rd);      check("pre_reset_period", rd, 32'd50);
    #1 reset = 1'b1;
    #1 check("async_reset_readdata", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(0, 2, rd);      check("post_reset_period", rd, 32'h22E97);
    bus_read(0, 0, rd);      check("post_reset_status", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
